// File: rtl/fx_ctrl_bank.sv
// fx_ctrl_bank: effect-pedal mode FSM, per-effect parameter bank and loop length/position tracker.
// Define FX_CTRL_AUTOREPEAT_EN to add hold-to-repeat stepping on the inc/dec keys.
module fx_ctrl_bank #(
    parameter int NUM_EFF    = 8,
    parameter int VAL_W      = 3,
    parameter int MAX_VAL    = 7,
    parameter int WRAP       = 1,
    parameter int LOOP_W     = 20,
    parameter int MAX_LOOP   = 1048575,
`ifdef FX_CTRL_AUTOREPEAT_EN
    parameter int REPEAT_DLY = 1536000,
    parameter int REPEAT_PER = 384000,
`endif
    parameter int SEL_W      = $clog2(NUM_EFF)
) (
    input  logic                     i_AUD_BCLK,
    input  logic                     i_rst_n,
    input  logic                     i_i2c_done,
    input  logic                     i_sample_valid,
    input  logic                     i_key_inc,
    input  logic                     i_key_dec,
    input  logic                     i_key_loop,
    input  logic                     i_key_mode,
    input  logic [SEL_W-1:0]         i_sel,
    output logic [2:0]               o_state,
    output logic [NUM_EFF*VAL_W-1:0] o_params,
    output logic [VAL_W-1:0]         o_cur_val,
    output logic [NUM_EFF-1:0]       o_sel_onehot,
    output logic [LOOP_W-1:0]        o_loop_len,
    output logic [LOOP_W-1:0]        o_loop_pos,
    output logic                     o_loop_active
);

    typedef enum logic [2:0] {
        ST_I2C   = 3'd0,
        ST_PLAY  = 3'd1,
        ST_SET   = 3'd2,
        ST_RECD  = 3'd3,
        ST_PLOOP = 3'd4
    } state_e;

    state_e             state_q;
    logic [LOOP_W-1:0]  loopLen_q;
    logic [LOOP_W-1:0]  loopPos_q;
    logic               loopActive_q;
    logic [VAL_W-1:0]   params_q [NUM_EFF];

    // Key bit order everywhere: {mode, loop, dec, inc}
    logic [3:0] keys;
    logic [3:0] sync1_q, sync2_q, sync3_q;
    logic [3:0] press;
    logic       incEv, decEv, loopEv, modeEv;

    assign keys  = {i_key_mode, i_key_loop, i_key_dec, i_key_inc};
    assign press = sync2_q & ~sync3_q;

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= keys;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

`ifdef FX_CTRL_AUTOREPEAT_EN
    // Hold counter counts cycles since the initial press; each repeat reloads it one period short.
    logic [31:0]      holdCnt_q;
    logic [SEL_W-1:0] selHist_q;
    logic             holdRun;
    logic             rptEv;

    assign holdRun = (state_q == ST_SET) && (sync2_q[0] ^ sync2_q[1]) && (i_sel == selHist_q);
    assign rptEv   = holdRun && (holdCnt_q == 32'(REPEAT_DLY));

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            holdCnt_q <= '0;
            selHist_q <= '0;
        end else begin
            selHist_q <= i_sel;
            if (!holdRun)
                holdCnt_q <= '0;
            else if (rptEv)
                holdCnt_q <= 32'(REPEAT_DLY - REPEAT_PER + 1);
            else
                holdCnt_q <= holdCnt_q + 32'd1;
        end
    end

    assign incEv = press[0] | (rptEv & sync2_q[0]);
    assign decEv = press[1] | (rptEv & sync2_q[1]);
`else
    assign incEv = press[0];
    assign decEv = press[1];
`endif
    assign loopEv = press[2];
    assign modeEv = press[3];

    logic             selValid;
    logic [VAL_W-1:0] curRaw;
    logic [VAL_W-1:0] newVal_d;

    assign selValid = int'(i_sel) < NUM_EFF;
    assign curRaw   = selValid ? params_q[i_sel] : '0;

    always_comb begin
        newVal_d = curRaw;
        if (incEv && !decEv) begin
            if (int'(curRaw) >= MAX_VAL)
                newVal_d = (WRAP != 0) ? '0 : VAL_W'(MAX_VAL);
            else
                newVal_d = curRaw + VAL_W'(1);
        end else if (decEv && !incEv) begin
            if (curRaw == '0)
                newVal_d = (WRAP != 0) ? VAL_W'(MAX_VAL) : '0;
            else
                newVal_d = curRaw - VAL_W'(1);
        end
    end

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_EFF; k++)
                params_q[k] <= '0;
        end else if (state_q == ST_SET && selValid) begin
            params_q[i_sel] <= newVal_d;
        end
    end

    logic [LOOP_W-1:0] lenInc;
    logic [LOOP_W-1:0] posInc;
    logic              hitMax;

    assign lenInc = loopLen_q + LOOP_W'(i_sample_valid);
    assign posInc = loopPos_q + LOOP_W'(1);
    assign hitMax = (lenInc == LOOP_W'(MAX_LOOP));

    // The strobe arriving on the exit edge of RECD_LOOP is still counted via lenInc.
    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_I2C;
            loopLen_q    <= '0;
            loopPos_q    <= '0;
            loopActive_q <= 1'b0;
        end else begin
            case (state_q)
                ST_I2C: begin
                    if (i_i2c_done)
                        state_q <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (modeEv) begin
                        state_q <= ST_SET;
                    end else if (loopEv) begin
                        state_q      <= ST_RECD;
                        loopLen_q    <= '0;
                        loopPos_q    <= '0;
                        loopActive_q <= 1'b1;
                    end
                end
                ST_SET: begin
                    if (modeEv)
                        state_q <= ST_PLAY;
                end
                ST_RECD: begin
                    loopLen_q <= lenInc;
                    if (hitMax || loopEv) begin
                        loopPos_q <= '0;
                        if (lenInc == '0) begin
                            state_q      <= ST_PLAY;
                            loopActive_q <= 1'b0;
                        end else begin
                            state_q <= ST_PLOOP;
                        end
                    end
                end
                ST_PLOOP: begin
                    if (i_sample_valid)
                        loopPos_q <= (posInc == loopLen_q) ? '0 : posInc;
                    if (loopEv) begin
                        state_q      <= ST_PLAY;
                        loopActive_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_PLAY;
                    loopActive_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_params = '0;
        for (int k = 0; k < NUM_EFF; k++)
            o_params[k*VAL_W +: VAL_W] = params_q[k];
    end

    always_comb begin
        o_sel_onehot = '0;
        if (state_q == ST_SET)
            for (int k = 0; k < NUM_EFF; k++)
                o_sel_onehot[k] = (int'(i_sel) == k);
    end

    assign o_state       = state_q;
    assign o_cur_val     = (state_q == ST_SET) ? curRaw : '0;
    assign o_loop_len    = loopLen_q;
    assign o_loop_pos    = loopPos_q;
    assign o_loop_active = loopActive_q;

endmodule

// File: tb/tb_fx_ctrl_bank.sv
// tb_fx_ctrl_bank: runs a wrapping/uncapped instance and a saturating MAX_LOOP=4 instance side by side
// on shared stimulus, checked every cycle against a behavioural model plus table and hand sequences.
module tb_fx_ctrl_bank;

    localparam int NUM_EFF      = 8;
    localparam int VAL_W        = 3;
    localparam int MAX_VAL      = 7;
    localparam int LOOP_W       = 20;
    localparam int BIG_MAX_LOOP = 1048575;
    localparam int ALT_MAX_LOOP = 4;

    logic       clk = 1'b0;
    logic       rstN;
    logic       i2cDone;
    logic       sampleValid;
    logic [3:0] keys;
    logic [2:0] sel;

    logic [1:0][2:0]               oState;
    logic [1:0][NUM_EFF*VAL_W-1:0] oParams;
    logic [1:0][VAL_W-1:0]         oCurVal;
    logic [1:0][NUM_EFF-1:0]       oSelOnehot;
    logic [1:0][LOOP_W-1:0]        oLoopLen;
    logic [1:0][LOOP_W-1:0]        oLoopPos;
    logic [1:0]                    oLoopActive;

    always #5 clk = ~clk;

    fx_ctrl_bank dutWrap (
        .i_AUD_BCLK     (clk),
        .i_rst_n        (rstN),
        .i_i2c_done     (i2cDone),
        .i_sample_valid (sampleValid),
        .i_key_inc      (keys[0]),
        .i_key_dec      (keys[1]),
        .i_key_loop     (keys[2]),
        .i_key_mode     (keys[3]),
        .i_sel          (sel),
        .o_state        (oState[0]),
        .o_params       (oParams[0]),
        .o_cur_val      (oCurVal[0]),
        .o_sel_onehot   (oSelOnehot[0]),
        .o_loop_len     (oLoopLen[0]),
        .o_loop_pos     (oLoopPos[0]),
        .o_loop_active  (oLoopActive[0])
    );

    fx_ctrl_bank #(.WRAP(0), .MAX_LOOP(ALT_MAX_LOOP)) dutSat (
        .i_AUD_BCLK     (clk),
        .i_rst_n        (rstN),
        .i_i2c_done     (i2cDone),
        .i_sample_valid (sampleValid),
        .i_key_inc      (keys[0]),
        .i_key_dec      (keys[1]),
        .i_key_loop     (keys[2]),
        .i_key_mode     (keys[3]),
        .i_sel          (sel),
        .o_state        (oState[1]),
        .o_params       (oParams[1]),
        .o_cur_val      (oCurVal[1]),
        .o_sel_onehot   (oSelOnehot[1]),
        .o_loop_len     (oLoopLen[1]),
        .o_loop_pos     (oLoopPos[1]),
        .o_loop_active  (oLoopActive[1])
    );

    int vecCount  = 0;
    int missCount = 0;

    // Reference model: index 0 wraps with no practical loop cap, index 1 saturates with cap ALT_MAX_LOOP
    int mState [2];
    int mParams [2][NUM_EFF];
    int mLen [2];
    int mPos [2];
    int hist [4][3];

    typedef struct {
        int sel;
        int op;
        int count;
        int expWrap;
        int expSat;
    } vec_t;

    vec_t tbl [9];

    task automatic checkOutput(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s dut%0d at %0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mState[d] = 0;
            mLen[d]   = 0;
            mPos[d]   = 0;
            for (int k = 0; k < NUM_EFF; k++) mParams[d][k] = 0;
        end
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 3; j++) hist[k][j] = 0;
    endtask

    // A key level seen at edge n-2 but not at n-3 is a press acting at edge n
    task automatic modelEdge();
        bit ev [4];
        for (int k = 0; k < 4; k++) begin
            ev[k] = (hist[k][1] == 1) && (hist[k][2] == 0);
            hist[k][2] = hist[k][1];
            hist[k][1] = hist[k][0];
            hist[k][0] = int'(keys[k]);
        end
        for (int d = 0; d < 2; d++) begin
            int ml = (d == 0) ? BIG_MAX_LOOP : ALT_MAX_LOOP;
            case (mState[d])
                0: if (i2cDone) mState[d] = 1;
                1: begin
                    if (ev[3]) mState[d] = 2;
                    else if (ev[2]) begin
                        mState[d] = 3;
                        mLen[d]   = 0;
                        mPos[d]   = 0;
                    end
                end
                2: begin
                    int v = mParams[d][sel];
                    if (ev[0] && !ev[1])
                        v = (d == 0) ? (v + 1) % (MAX_VAL + 1) : ((v < MAX_VAL) ? v + 1 : MAX_VAL);
                    else if (ev[1] && !ev[0])
                        v = (d == 0) ? (v + MAX_VAL) % (MAX_VAL + 1) : ((v > 0) ? v - 1 : 0);
                    mParams[d][sel] = v;
                    if (ev[3]) mState[d] = 1;
                end
                3: begin
                    if (sampleValid) mLen[d]++;
                    if (mLen[d] == ml) begin
                        mState[d] = 4;
                        mPos[d]   = 0;
                    end else if (ev[2]) begin
                        mState[d] = (mLen[d] == 0) ? 1 : 4;
                        mPos[d]   = 0;
                    end
                end
                4: begin
                    if (sampleValid) mPos[d] = (mPos[d] + 1) % mLen[d];
                    if (ev[2]) mState[d] = 1;
                end
                default: mState[d] = 1;
            endcase
        end
    endtask

    task automatic checkAll();
        for (int d = 0; d < 2; d++) begin
            logic [31:0] pf = '0;
            for (int k = 0; k < NUM_EFF; k++) pf = pf | (32'(mParams[d][k]) << (k * VAL_W));
            checkOutput("state", d, 32'(oState[d]), 32'(mState[d]));
            checkOutput("params", d, 32'(oParams[d]), pf);
            checkOutput("cur_val", d, 32'(oCurVal[d]), (mState[d] == 2) ? 32'(mParams[d][sel]) : 32'd0);
            checkOutput("sel_onehot", d, 32'(oSelOnehot[d]), (mState[d] == 2) ? (32'd1 << sel) : 32'd0);
            checkOutput("loop_len", d, 32'(oLoopLen[d]), 32'(mLen[d]));
            checkOutput("loop_pos", d, 32'(oLoopPos[d]), 32'(mPos[d]));
            checkOutput("loop_active", d, 32'(oLoopActive[d]), (mState[d] == 3 || mState[d] == 4) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rstN) modelReset();
        else modelEdge();
        @(negedge clk);
        checkAll();
    endtask

    task automatic pressKeys(input logic [3:0] m, input int hold);
        keys = keys | m;
        repeat (hold) tick();
        keys = keys & ~m;
        repeat (4) tick();
    endtask

    task automatic strobe();
        sampleValid = 1'b1;
        tick();
        sampleValid = 1'b0;
        tick();
    endtask

    task automatic applyStimulus(input vec_t v);
        sel = 3'(v.sel);
        tick();
        for (int n = 0; n < v.count; n++) begin
            case (v.op)
                1: pressKeys(4'b0001, 2);
                2: pressKeys(4'b0010, 2);
                3: pressKeys(4'b0011, 2);
                default: tick();
            endcase
        end
    endtask

    task automatic resetToPlay();
        rstN = 1'b0;
        repeat (2) tick();
        rstN = 1'b1;
        tick();
    endtask

    initial begin
        tbl[0] = '{3, 1, 9, 1, 7};
        tbl[1] = '{3, 2, 1, 0, 6};
        tbl[2] = '{0, 2, 1, 7, 0};
        tbl[3] = '{0, 3, 1, 7, 0};
        tbl[4] = '{0, 1, 2, 1, 2};
        tbl[5] = '{5, 1, 3, 3, 3};
        tbl[6] = '{5, 2, 5, 6, 0};
        tbl[7] = '{7, 1, 8, 0, 7};
        tbl[8] = '{3, 0, 1, 0, 6};

        rstN        = 1'b0;
        i2cDone     = 1'b0;
        sampleValid = 1'b0;
        keys        = '0;
        sel         = '0;
        modelReset();
        repeat (2) tick();
        rstN = 1'b1;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) checkOutput("wait_i2c", d, 32'(oState[d]), 32'd0);
        i2cDone = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput("i2c_to_play", d, 32'(oState[d]), 32'd1);
            checkOutput("params_reset", d, 32'(oParams[d]), 32'd0);
        end

        $display("[TB] parameter table");
        pressKeys(4'b1000, 2);
        for (int d = 0; d < 2; d++) checkOutput("enter_set", d, 32'(oState[d]), 32'd2);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i]);
            checkOutput("tbl_cur_wrap", 0, 32'(oCurVal[0]), 32'(tbl[i].expWrap));
            checkOutput("tbl_cur_sat", 1, 32'(oCurVal[1]), 32'(tbl[i].expSat));
            if (i == 0) begin
                checkOutput("params_after_9inc", 0, 32'(oParams[0]), 32'h200);
                checkOutput("params_after_9inc", 1, 32'(oParams[1]), 32'hE00);
            end
        end
        checkOutput("tbl_final_bank", 0, 32'(oParams[0]), 32'h030001);
        checkOutput("tbl_final_bank", 1, 32'(oParams[1]), 32'hE00C02);

        sel     = 3'd1;
        keys[0] = 1'b1;
        repeat (500) tick();
        keys[0] = 1'b0;
        repeat (4) tick();
        for (int d = 0; d < 2; d++) checkOutput("long_hold_one_step", d, 32'(oCurVal[d]), 32'd1);
        pressKeys(4'b1000, 2);

        $display("[TB] loop sequences");
        resetToPlay();
        pressKeys(4'b0100, 2);
        repeat (5) strobe();
        pressKeys(4'b0100, 2);
        checkOutput("loop_state", 0, 32'(oState[0]), 32'd4);
        checkOutput("loop_len5", 0, 32'(oLoopLen[0]), 32'd5);
        checkOutput("cap_then_exit", 1, 32'(oState[1]), 32'd1);
        checkOutput("cap_len", 1, 32'(oLoopLen[1]), 32'd4);
        repeat (12) strobe();
        checkOutput("pos_after_12", 0, 32'(oLoopPos[0]), 32'd2);
        checkOutput("pos_held_play", 1, 32'(oLoopPos[1]), 32'd1);
        pressKeys(4'b0100, 2);
        checkOutput("ploop_to_play", 0, 32'(oState[0]), 32'd1);
        checkOutput("play_to_recd", 1, 32'(oState[1]), 32'd3);

        resetToPlay();
        pressKeys(4'b0100, 2);
        pressKeys(4'b0100, 2);
        for (int d = 0; d < 2; d++) begin
            checkOutput("empty_loop_state", d, 32'(oState[d]), 32'd1);
            checkOutput("empty_loop_len", d, 32'(oLoopLen[d]), 32'd0);
        end

        pressKeys(4'b0100, 2);
        repeat (3) strobe();
        checkOutput("recd_len3", 0, 32'(oLoopLen[0]), 32'd3);
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        checkAll();
        for (int d = 0; d < 2; d++) begin
            checkOutput("midrec_reset_state", d, 32'(oState[d]), 32'd0);
            checkOutput("midrec_reset_len", d, 32'(oLoopLen[d]), 32'd0);
        end
        tick();
        rstN = 1'b1;

        $display("[TB] random phase");
        for (int c = 0; c < 2000; c++) begin
            if (!rstN) rstN = 1'b1;
            else if ($urandom_range(0, 699) == 0) rstN = 1'b0;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 9) == 0) keys[k] = ~keys[k];
            if ($urandom_range(0, 15) == 0) sel = 3'($urandom_range(0, 7));
            sampleValid = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
